// File: rtl/writeback_queue.sv
// Register-file writeback queue: buffers multi-cycle unit writes, drains one per cycle,
// and (when WBQ_FORWARD_EN is defined) forwards the youngest pending write to two read ports.

`ifdef WBQ_FORWARD_EN
// One forwarding read port: scans entries oldest to youngest so the youngest match wins.
module wbq_fwd_port #(
    parameter int DEPTH = 4
) (
    input  logic [4:0]                  read_reg,
    input  logic [DEPTH-1:0][4:0]       ent_reg,
    input  logic [DEPTH-1:0][31:0]      ent_data,
    input  logic [DEPTH-1:0]            ent_vld,
    output logic                        hit,
    output logic [31:0]                 data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_vld[k] && ent_reg[k] == read_reg && read_reg != 5'd0) begin
                hit  = 1'b1;
                data = ent_data[k];
            end
        end
    end
endmodule
`endif

module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [31:0]   in_data,
    input  logic          wb_stall,
    output logic          reg_write,
    output logic [4:0]    write_reg,
    output logic [31:0]   write_data,
    input  logic [4:0]    read_reg1,
    input  logic [4:0]    read_reg2,
    output logic          fwd_hit1,
    output logic [31:0]   fwd_data1,
    output logic          fwd_hit2,
    output logic [31:0]   fwd_data2,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    mem_reg  [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] head, tail;
    logic          push, pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign reg_write = !empty && !wb_stall;
    assign pop       = reg_write;
    // Writes to r0 complete the handshake but are dropped here.
    assign push      = in_valid && in_ready && (in_reg != 5'd0);

    assign write_reg  = empty ? 5'd0  : mem_reg[head];
    assign write_data = empty ? 32'd0 : mem_data[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[tail]  <= in_reg;
            mem_data[tail] <= in_data;
        end
    end

`ifdef WBQ_FORWARD_EN
    // Entries rotated into age order (index 0 = head) with a validity mask from count.
    logic [DEPTH-1:0][4:0]  ord_reg;
    logic [DEPTH-1:0][31:0] ord_data;
    logic [DEPTH-1:0]       ord_vld;
    logic [1:0][4:0]        rd_addr;
    logic [1:0]             fwd_hit;
    logic [1:0][31:0]       fwd_data;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ord_reg[k]  = mem_reg[head + AW'(k)];
            ord_data[k] = mem_data[head + AW'(k)];
            ord_vld[k]  = CW'(k) < count;
        end
    end

    assign rd_addr = {read_reg2, read_reg1};

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        wbq_fwd_port #(.DEPTH(DEPTH)) u_fwd (
            .read_reg (rd_addr[p]),
            .ent_reg  (ord_reg),
            .ent_data (ord_data),
            .ent_vld  (ord_vld),
            .hit      (fwd_hit[p]),
            .data     (fwd_data[p])
        );
    end

    assign fwd_hit1  = fwd_hit[0];
    assign fwd_data1 = fwd_data[0];
    assign fwd_hit2  = fwd_hit[1];
    assign fwd_data2 = fwd_data[1];
`else
    // Without forwarding, decode must interlock on !empty.
    logic unused_read;
    assign unused_read = ^{read_reg1, read_reg2};
    assign fwd_hit1  = 1'b0;
    assign fwd_data1 = 32'd0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data2 = 32'd0;
`endif
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Initiator for the register file write port: buffers register write requests from multi-cycle units (load, mul/div) and drains them one per cycle into reg_write/write_reg/write_data.
- Provides youngest-match forwarding of still-pending writes for the two register file read addresses, so decode sees architecturally correct values.
- Sits between execution units and the register file.

Parameters:
- DEPTH, 4, number of pending-write entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  producer presents a write request.
- in_ready  output  1  queue can accept a request; equals !full.
- in_reg  input  5  destination register of the request.
- in_data  input  32  data of the request.
- wb_stall  input  1  register file write port is taken by another writer this cycle.
- reg_write  output  1  write enable to the register file.
- write_reg  output  5  register file write address (head entry).
- write_data  output  32  register file write data (head entry).
- read_reg1  input  5  register file read address, port 1.
- read_reg2  input  5  register file read address, port 2.
- fwd_hit1  output  1  pending write matches read_reg1.
- fwd_data1  output  32  forwarded data for read_reg1.
- fwd_hit2  output  1  pending write matches read_reg2.
- fwd_data2  output  32  forwarded data for read_reg2.
- count  output  CW  number of pending entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage is a circular FIFO with head and tail pointers wrapping modulo DEPTH, plus a count register.
- Reset (asynchronous, any time, including mid-drain):
  - head, tail and count go to 0; all pending writes are discarded.
  - Outputs while reset is held: empty=1, full=0, in_ready=1, reg_write=0, fwd_hit1/2=0.
  - Entry contents are don't-care but must never be forwarded while empty.
- Push (accept):
  - Occurs when in_valid && in_ready at a rising edge.
  - If in_reg != 0, {in_reg, in_data} is written at tail and tail increments.
  - If in_reg == 0, the handshake completes but nothing is enqueued; count is unchanged.
- Pop (drain):
  - Combinational: reg_write = !empty && !wb_stall.
  - write_reg and write_data always show the head entry; both are 0 when empty.
  - The head entry retires at the rising edge where reg_write=1.
- Latency:
  - An entry accepted at edge N is at the earliest presented at edge N+1.
  - There is no same-cycle pass-through from in_* to write_*.
- Full:
  - in_ready=0 when full, even if a pop happens in the same cycle. No push-through at full.
- Simultaneous push and pop (not full, not empty): count is unchanged; both pointers advance.
- wb_stall held: the head entry is held. The queue fills and in_ready drops at count == DEPTH.
- Forwarding, evaluated independently for port k = 1, 2:
  - fwd_hitk = 1 if any valid entry has reg == read_regk and read_regk != 0.
  - fwd_datak = data of the youngest matching entry (nearest to tail); 0 when there is no hit.
  - The head entry being written this cycle still counts as pending.
  - Forwarding is purely combinational from the current queue state. Requests arriving this cycle on in_* are not forwarded.
- Ordering: writes to the same register retire in acceptance order, so the last write wins in the register file.

Optional Feature:
- WBQ_FORWARD_EN defined: forwarding logic is built exactly as specified above.
- WBQ_FORWARD_EN undefined: fwd_hit1/2 are tied to 0 and fwd_data1/2 to 0.
  - Ports remain present; the queue and drain behaviour are unchanged.
  - In this configuration the pipeline must interlock on !empty instead of using forwarded data.

Test Plan:
- Reset, then push (r5, 0x0000_00AA) with wb_stall=0 -> next cycle reg_write=1, write_reg=5, write_data=0xAA; the following cycle empty=1, count=0.
- wb_stall=1; push r1=0x11, r2=0x22, r3=0x33, r4=0x44 -> full=1, in_ready=0, count=4. Release stall -> writes retire r1, r2, r3, r4 on 4 consecutive cycles; in_ready=1 after the first retire.
- Push r7=0x100 then r7=0x200 with wb_stall=1, read_reg1=7, read_reg2=0 -> fwd_hit1=1, fwd_data1=0x200, fwd_hit2=0. After both drain -> fwd_hit1=0.
- Push (r0, 0xDEAD) -> in_ready=1, handshake completes, count stays 0, reg_write never asserts.
- Queue holding 3 entries, assert reset mid-drain -> same cycle count=0, empty=1, reg_write=0. After reset release, no stale write appears.
- With WBQ_FORWARD_EN undefined, rerun the third scenario -> fwd_hit1=0, fwd_data1=0; drain order unchanged.
